// File: rtl/el_scan_ctrl_pkg.sv
// Shared types and default timing for the EL panel scan controller.
package el_pkg;

  localparam int unsigned CNT_W = 9;
  localparam int unsigned IDX_W = 8;

  localparam int unsigned DEF_H_ACTIVE = 160;
  localparam int unsigned DEF_H_FRONT  = 4;
  localparam int unsigned DEF_H_SYNC   = 8;
  localparam int unsigned DEF_H_BACK   = 8;
  localparam int unsigned DEF_V_ACTIVE = 240;
  localparam int unsigned DEF_V_FRONT  = 1;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HSYNC,
    S_HBACK,
    S_HACT,
    S_HFRONT
  } hstate_e;

  typedef enum logic [1:0] {
    VP_SYNC,
    VP_BACK,
    VP_ACT,
    VP_FRONT
  } vphase_e;

endpackage

// File: rtl/el_scan_ctrl_if.sv
// Scan timing bundle between the controller and the pixel generator.
interface el_scan_ctrl_if;
  import el_pkg::*;

  logic             run;
  logic             HS;
  logic             VS;
  logic             DE;
  logic [IDX_W-1:0] col;
  logic [IDX_W-1:0] line;
  logic             frame;
  logic             sof;
  logic             busy;

  modport master (input run, output HS, VS, DE, col, line, frame, sof, busy);
  modport slave  (output run, input HS, VS, DE, col, line, frame, sof, busy);
endinterface

// File: rtl/el_scan_ctrl_phase_cnt.sv
// Length-loadable phase counter; exposes its next value so callers can register outputs in step.
module el_phase_cnt
  import el_pkg::*;
(
  input  logic             Vclk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] cnt_nxt_c,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt;

  assign tc_c = (cnt == len - CNT_W'(1));

  always_comb begin
    cnt_nxt_c = cnt;
    if (clr) begin
      cnt_nxt_c = '0;
    end else if (en) begin
      cnt_nxt_c = tc_c ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Vclk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt_c;
    end
  end

endmodule

// File: rtl/el_scan_ctrl.sv
// Scan timing sequencer: horizontal FSM plus vertical phase tracking, frame-boundary start/stop.
module el_scan_ctrl
  import el_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK
) (
  input  logic              Vclk,
  input  logic              rst,
  el_scan_ctrl_if.master    bus
);

  hstate_e          hstate, hstate_n;
  vphase_e          vphase, vphase_n;
  logic [CNT_W-1:0] hlen, vlen, hcnt_n, vcnt_n;
  logic             htc, vtc;
  logic             line_end_c, frame_end_c, de_n;

  // Phase lengths for the current horizontal state / vertical phase
  always_comb begin
    hlen = CNT_W'(H_SYNC);
    case (hstate)
      S_HBACK:  hlen = CNT_W'(H_BACK);
      S_HACT:   hlen = CNT_W'(H_ACTIVE);
      S_HFRONT: hlen = CNT_W'(H_FRONT);
      default:  hlen = CNT_W'(H_SYNC);
    endcase
    vlen = CNT_W'(V_SYNC);
    case (vphase)
      VP_BACK:  vlen = CNT_W'(V_BACK);
      VP_ACT:   vlen = CNT_W'(V_ACTIVE);
      VP_FRONT: vlen = CNT_W'(V_FRONT);
      default:  vlen = CNT_W'(V_SYNC);
    endcase
  end

  el_phase_cnt u_hcnt (
    .Vclk      (Vclk),
    .rst       (rst),
    .en        (hstate != S_IDLE),
    .clr       (hstate == S_IDLE),
    .len       (hlen),
    .cnt_nxt_c (hcnt_n),
    .tc_c      (htc)
  );

  el_phase_cnt u_vcnt (
    .Vclk      (Vclk),
    .rst       (rst),
    .en        (line_end_c),
    .clr       (hstate == S_IDLE),
    .len       (vlen),
    .cnt_nxt_c (vcnt_n),
    .tc_c      (vtc)
  );

  always_comb begin
    hstate_n    = hstate;
    vphase_n    = vphase;
    line_end_c  = (hstate == S_HFRONT) && htc;
    frame_end_c = line_end_c && (vphase == VP_FRONT) && vtc;
    case (hstate)
      S_IDLE:   if (bus.run) hstate_n = S_HSYNC;
      S_HSYNC:  if (htc) hstate_n = S_HBACK;
      S_HBACK:  if (htc) hstate_n = S_HACT;
      S_HACT:   if (htc) hstate_n = S_HFRONT;
      // A frame only ends into IDLE when run has dropped by its last cycle
      S_HFRONT: if (htc) hstate_n = (frame_end_c && !bus.run) ? S_IDLE : S_HSYNC;
      default:  hstate_n = S_IDLE;
    endcase
    if (line_end_c && vtc) begin
      case (vphase)
        VP_SYNC:  vphase_n = VP_BACK;
        VP_BACK:  vphase_n = VP_ACT;
        VP_ACT:   vphase_n = VP_FRONT;
        default:  vphase_n = VP_SYNC;
      endcase
    end
  end

  always_ff @(posedge Vclk) begin
    if (rst) begin
      hstate <= S_IDLE;
      vphase <= VP_SYNC;
    end else begin
      hstate <= hstate_n;
      vphase <= vphase_n;
    end
  end

  assign de_n = (hstate_n == S_HACT) && (vphase_n == VP_ACT);

  // Outputs are registered from next-state values so they align with the state edge
  always_ff @(posedge Vclk) begin
    if (rst) begin
      bus.HS    <= 1'b0;
      bus.VS    <= 1'b0;
      bus.DE    <= 1'b0;
      bus.col   <= '0;
      bus.line  <= '0;
      bus.frame <= 1'b0;
      bus.sof   <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      bus.HS    <= (hstate_n == S_HSYNC);
      bus.VS    <= (hstate_n != S_IDLE) && (vphase_n == VP_SYNC);
      bus.DE    <= de_n;
      bus.col   <= de_n ? IDX_W'(hcnt_n) : '0;
      bus.line  <= ((hstate_n != S_IDLE) && (vphase_n == VP_ACT)) ? IDX_W'(vcnt_n) : '0;
      bus.frame <= bus.frame ^ frame_end_c;
      bus.sof   <= bus.run && ((hstate == S_IDLE) || frame_end_c);
      bus.busy  <= (hstate_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_el_scan_ctrl.sv
// Bench for el_scan_ctrl with reduced timing: vector table, directed frame sequences, random run/rst vs model.
module tb_el_scan_ctrl;

  localparam int HA = 6, HF = 1, HSY = 3, HB = 2;
  localparam int VA = 5, VF = 1, VSY = 2, VB = 2;
  localparam int LINE   = HSY + HB + HA + HF;
  localparam int NLINES = VSY + VB + VA + VF;
  localparam int FRAME  = LINE * NLINES;

  typedef logic [21:0] ovec_t;

  logic Vclk = 1'b0;
  logic rst;
  always #5 Vclk = ~Vclk;

  el_scan_ctrl_if bus ();

  el_scan_ctrl #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .Vclk (Vclk),
    .rst  (rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: position within the frame, derived outputs by arithmetic
  int m_pos = 0;
  bit m_act = 1'b0;
  bit m_frame = 1'b0;

  function automatic ovec_t model_out();
    int l, h;
    logic hs, vs, de, act_line;
    logic [7:0] c, ln;
    if (!m_act) return {3'b000, 16'h0000, m_frame, 2'b00};
    l = m_pos / LINE;
    h = m_pos % LINE;
    hs = (h < HSY);
    vs = (l < VSY);
    act_line = (l >= VSY + VB) && (l < VSY + VB + VA);
    de = act_line && (h >= HSY + HB) && (h < HSY + HB + HA);
    c  = de ? 8'(h - HSY - HB) : 8'd0;
    ln = act_line ? 8'(l - VSY - VB) : 8'd0;
    return {hs, vs, de, c, ln, m_frame, (m_pos == 0), 1'b1};
  endfunction

  function automatic ovec_t dut_out();
    return {bus.HS, bus.VS, bus.DE, bus.col, bus.line, bus.frame, bus.sof, bus.busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge Vclk);
    if (rst) begin
      m_act = 1'b0; m_pos = 0; m_frame = 1'b0;
    end else if (!m_act) begin
      if (bus.run) begin m_act = 1'b1; m_pos = 0; end
    end else if (m_pos == FRAME - 1) begin
      m_frame = ~m_frame;
      if (bus.run) m_pos = 0; else m_act = 1'b0;
    end else begin
      m_pos++;
    end
    #1;
    check({tag, "_model"}, 32'(dut_out()), 32'(model_out()));
  endtask

  typedef struct {
    bit         rst;
    bit         run;
    logic [5:0] exp;   // {HS, VS, DE, sof, busy, frame}
  } vec_t;

  vec_t vt[11];

  initial begin
    int k, de_cnt, hs_cnt, vs_cnt, busy_cnt, first_de, max_col, max_line;
    int sof_q[$];
    logic [2:0] fseq;

    vt[0]  = '{1'b1, 1'b0, 6'b000000};
    vt[1]  = '{1'b0, 1'b0, 6'b000000};
    vt[2]  = '{1'b0, 1'b1, 6'b110110};
    vt[3]  = '{1'b0, 1'b1, 6'b110010};
    vt[4]  = '{1'b0, 1'b1, 6'b110010};
    vt[5]  = '{1'b0, 1'b1, 6'b010010};
    vt[6]  = '{1'b0, 1'b0, 6'b010010};
    vt[7]  = '{1'b1, 1'b0, 6'b000000};
    vt[8]  = '{1'b0, 1'b0, 6'b000000};
    vt[9]  = '{1'b1, 1'b1, 6'b000000};
    vt[10] = '{1'b0, 1'b1, 6'b110110};

    rst = 1'b1;
    bus.run = 1'b0;

    for (int i = 0; i < 11; i++) begin
      rst = vt[i].rst;
      bus.run = vt[i].run;
      tick("vec");
      check($sformatf("vec%0d", i),
            32'({bus.HS, bus.VS, bus.DE, bus.sof, bus.busy, bus.frame}), 32'(vt[i].exp));
    end

    // Reset then idle with run low
    rst = 1'b1; bus.run = 1'b0;
    tick("idle_rst");
    rst = 1'b0;
    repeat (100) tick("idle");
    check("idle_all_zero", 32'(dut_out()), 32'd0);

    // Three continuous frames
    bus.run = 1'b1;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; busy_cnt = 0; first_de = -1; max_col = 0; max_line = 0;
    fseq = '0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick("run3");
      if (bus.sof) begin
        if (sof_q.size() < 3) fseq[2 - sof_q.size()] = bus.frame;
        sof_q.push_back(c);
      end
      if (bus.DE) begin
        de_cnt++;
        if (first_de < 0) first_de = c;
        if (int'(bus.col) > max_col) max_col = int'(bus.col);
      end
      if (int'(bus.line) > max_line) max_line = int'(bus.line);
      if (bus.HS) hs_cnt++;
      if (bus.VS) vs_cnt++;
      if (bus.busy) busy_cnt++;
    end
    check("sof_count", 32'(sof_q.size()), 32'd3);
    if (sof_q.size() == 3) begin
      check("sof_period1", 32'(sof_q[1] - sof_q[0]), 32'(FRAME));
      check("sof_period2", 32'(sof_q[2] - sof_q[1]), 32'(FRAME));
    end
    check("frame_seq", 32'(fseq), 32'b010);
    check("de_count", 32'(de_cnt), 32'(3 * HA * VA));
    check("hs_count", 32'(hs_cnt), 32'(3 * NLINES * HSY));
    check("vs_count", 32'(vs_cnt), 32'(3 * VSY * LINE));
    check("no_gap", 32'(busy_cnt), 32'(3 * FRAME));
    check("first_de", 32'(first_de), 32'((VSY + VB) * LINE + HSY + HB));
    check("max_col", 32'(max_col), 32'(HA - 1));
    check("max_line", 32'(max_line), 32'(VA - 1));

    // Drop run mid-frame: frame must complete, then idle
    rst = 1'b1; tick("drop_rst");
    rst = 1'b0; bus.run = 1'b1;
    tick("drop");
    check("drop_sof", 32'(bus.sof), 32'd1);
    k = 0;
    repeat (5 * LINE) begin tick("drop"); k++; end
    bus.run = 1'b0;
    while (bus.busy && k < 3 * FRAME) begin tick("drop"); k++; end
    check("drop_busy_fall", 32'(k), 32'(FRAME));
    check("drop_frame", 32'(bus.frame), 32'd1);

    // Reset during active video, then restart with run held
    bus.run = 1'b1;
    tick("arst");
    repeat ((VSY + VB + 2) * LINE + HSY + HB + 2) tick("arst");
    check("arst_pre", 32'({bus.DE, bus.col, bus.line}), 32'({1'b1, 8'd2, 8'd2}));
    rst = 1'b1;
    tick("arst");
    check("arst_clear", 32'(dut_out()), 32'd0);
    rst = 1'b0;
    tick("arst");
    check("arst_restart", 32'({bus.sof, bus.HS, bus.VS, bus.busy}), 32'b1111);

    // Random run toggling with occasional reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) bus.run = ~bus.run;
      rst = ($urandom_range(0, 399) == 0);
      tick("rand");
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
